prng_seq_ctrl: RTL and testbench

- Sequencer for the pseudo-random number generator in stepped mode (PRNG mode input tied 0): loads the seed, issues one step per granted slot, buffers returned vectors in a FIFO and delivers them downstream over valid/ready.
- Terminates a run on vector-count limit, PRNG stop-code hit or abort; reports status.
- Sits between the BIST/host config registers, the PRNG and the systolic-array input feeder.

---
 rtl/prng_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_prng_seq_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_seq_ctrl.sv
// Stepped-mode PRNG sequencer: seeds the generator, issues credit-limited steps,
// buffers responses in a small FIFO and streams them downstream over valid/ready.
module prng_seq_ctrl #(
   parameter int DATA_WIDTH = 49,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int PRNG_LAT   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [DATA_WIDTH-1:0] i_seed,
   input  logic [DATA_WIDTH-1:0] i_stop_code,
   input  logic [CNT_W-1:0]      i_max_vec,
   output logic                  o_prng_vld,
   output logic [DATA_WIDTH-1:0] o_prng_data,
   output logic [DATA_WIDTH-1:0] o_prng_stop_code,
   input  logic                  i_prng_vld,
   input  logic [DATA_WIDTH-1:0] i_prng_data,
   input  logic                  i_prng_done,
   output logic                  o_vec_vld,
   output logic [DATA_WIDTH-1:0] o_vec_data,
   input  logic                  i_vec_rdy,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_stop_hit,
   output logic [CNT_W-1:0]      o_vec_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Credit counters are sized with headroom so fifo_count + outstanding never wraps.
   localparam int CW = $clog2(FIFO_DEPTH + PRNG_LAT) + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [DATA_WIDTH-1:0] stop_code_q;
   logic [CNT_W-1:0]      max_q;
   logic [CNT_W-1:0]      issued;
   logic [CNT_W-1:0]      vec_cnt;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         fifo_count;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic                  first_step;
   logic                  stop_hit;

   logic issue;
   logic push;
   logic pop;
   logic accept_start;
   logic last_issue;

   // Pops are not credited until the following cycle, so only registered counts are used.
   assign issue = (state == RUN) && (issued < max_q) && !i_abort && !i_prng_done &&
                  ((fifo_count + outstanding) < CW'(FIFO_DEPTH));
   assign last_issue   = issue && (issued == max_q - CNT_W'(1));
   assign push         = i_prng_vld && ((state == RUN) || (state == DRAIN));
   assign pop          = o_vec_vld && i_vec_rdy;
   assign accept_start = i_start && ((state == IDLE) || (state == DONE));

   assign o_prng_vld       = issue;
   assign o_prng_data      = (issue && first_step) ? seed_q : '0;
   assign o_prng_stop_code = stop_code_q;
   assign o_vec_vld        = (fifo_count != '0);
   assign o_vec_data       = o_vec_vld ? mem[rd_ptr] : '0;
   assign o_busy           = (state == RUN) || (state == DRAIN);
   assign o_done           = (state == DONE);
   assign o_stop_hit       = stop_hit;
   assign o_vec_cnt        = vec_cnt;

   // Run control: config latching, state transitions and the sticky stop flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         seed_q      <= '0;
         stop_code_q <= '0;
         max_q       <= '0;
         stop_hit    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept_start) begin
                  seed_q      <= i_seed;
                  stop_code_q <= i_stop_code;
                  max_q       <= i_max_vec;
                  stop_hit    <= 1'b0;
                  state       <= (i_max_vec == '0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (i_prng_done) begin
                  stop_hit <= 1'b1;
               end
               if (last_issue || i_abort || i_prng_done) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((outstanding == '0) && (fifo_count == '0)) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Step bookkeeping: issued count, in-flight credits and the seed-on-first-step flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         issued      <= '0;
         outstanding <= '0;
         first_step  <= 1'b0;
      end else if (accept_start) begin
         issued      <= '0;
         outstanding <= '0;
         first_step  <= 1'b1;
      end else begin
         if (issue) begin
            issued     <= issued + CNT_W'(1);
            first_step <= 1'b0;
         end
         case ({issue, push})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Output FIFO pointers and occupancy; push and pop may coincide even when full.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= i_prng_data;
      end
   end

   // Delivered-vector counter, saturating so long runs never wrap to zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vec_cnt <= '0;
      end else if (accept_start) begin
         vec_cnt <= '0;
      end else if (pop && (vec_cnt != '1)) begin
         vec_cnt <= vec_cnt + CNT_W'(1);
      end
   end

   // The credit rule must make overflow and unsolicited responses impossible.
   always @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));
         assert (!(push && (outstanding == '0)));
      end
   end

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Scenario bench for prng_seq_ctrl: a latency-1 PRNG model feeds a scoreboard
// queue that is checked in order as vectors leave the DUT.
module tb_prng_seq_ctrl;

   localparam int DW    = 49;
   localparam int CW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic          i_abort;
   logic [DW-1:0] i_seed;
   logic [DW-1:0] i_stop_code;
   logic [CW-1:0] i_max_vec;
   logic          o_prng_vld;
   logic [DW-1:0] o_prng_data;
   logic [DW-1:0] o_prng_stop_code;
   logic          i_prng_vld;
   logic [DW-1:0] i_prng_data;
   logic          i_prng_done;
   logic          o_vec_vld;
   logic [DW-1:0] o_vec_data;
   logic          i_vec_rdy;
   logic          o_busy;
   logic          o_done;
   logic          o_stop_hit;
   logic [CW-1:0] o_vec_cnt;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] exp_q[$];
   int            step_cnt  = 0;
   int            resp_cnt  = 0;
   int            deliv_cnt = 0;
   int            done_at   = 0;
   logic [DW-1:0] cur_seed  = '0;
   logic [DW-1:0] prng_st   = '0;
   logic [DW-1:0] pend_data = '0;
   logic          pend_vld  = 1'b0;
   logic [DW-1:0] step_exp;
   logic [DW-1:0] sb_exp;
   logic [DW-1:0] held_data = '0;
   logic          held_vld  = 1'b0;

   always #5 clk = ~clk;

   prng_seq_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH), .PRNG_LAT(1)) dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .i_seed           (i_seed),
      .i_stop_code      (i_stop_code),
      .i_max_vec        (i_max_vec),
      .o_prng_vld       (o_prng_vld),
      .o_prng_data      (o_prng_data),
      .o_prng_stop_code (o_prng_stop_code),
      .i_prng_vld       (i_prng_vld),
      .i_prng_data      (i_prng_data),
      .i_prng_done      (i_prng_done),
      .o_vec_vld        (o_vec_vld),
      .o_vec_data       (o_vec_data),
      .i_vec_rdy        (i_vec_rdy),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_stop_hit       (o_stop_hit),
      .o_vec_cnt        (o_vec_cnt)
   );

   function automatic logic [DW-1:0] prng_next(input logic [DW-1:0] s);
      logic [DW-1:0] x;
      x = s;
      x = x ^ (x << 7);
      x = x ^ (x >> 11);
      x = x ^ (x << 3);
      if (x == '0) x = 1;
      return x;
   endfunction

   // PRNG model: answers each step one cycle later and queues the expected vector.
   initial begin
      i_prng_vld  = 1'b0;
      i_prng_data = '0;
      i_prng_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         i_prng_vld  = pend_vld;
         i_prng_data = pend_vld ? pend_data : '0;
         i_prng_done = pend_vld && (done_at == resp_cnt + 1);
         if (pend_vld) begin
            exp_q.push_back(pend_data);
            resp_cnt++;
         end
         #2;
         pend_vld = o_prng_vld;
         if (o_prng_vld) begin
            step_exp = (step_cnt == 0) ? cur_seed : '0;
            checks++;
            if (o_prng_data !== step_exp) begin
               errors++;
               $display("[TB] FAIL step_data #%0d: got %h expected %h", step_cnt, o_prng_data, step_exp);
            end
            prng_st   = (step_cnt == 0) ? cur_seed : prng_next(prng_st);
            pend_data = prng_st;
            step_cnt++;
         end
      end
   end

   // Downstream monitor: pops the scoreboard on each transfer and checks hold stability.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (held_vld && o_vec_vld) begin
            checks++;
            if (o_vec_data !== held_data) begin
               errors++;
               $display("[TB] FAIL hold_stable: got %h expected %h", o_vec_data, held_data);
            end
         end
         if (o_vec_vld && i_vec_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL vec_data: got %h expected none (queue empty)", o_vec_data);
            end else begin
               sb_exp = exp_q.pop_front();
               if (o_vec_data !== sb_exp) begin
                  errors++;
                  $display("[TB] FAIL vec_data #%0d: got %h expected %h", deliv_cnt, o_vec_data, sb_exp);
               end
            end
            deliv_cnt++;
         end
         held_vld  = o_vec_vld && !i_vec_rdy;
         held_data = o_vec_data;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [DW-1:0] seed, input logic [DW-1:0] stop, input int max);
      cur_seed    = seed;
      step_cnt    = 0;
      resp_cnt    = 0;
      deliv_cnt   = 0;
      i_seed      = seed;
      i_stop_code = stop;
      i_max_vec   = CW'(max);
      i_start     = 1'b1;
      tick();
      i_start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (o_done) break;
         tick();
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_seed = '0;
      i_stop_code = '0;
      i_max_vec = '0;
      i_vec_rdy = 1'b0;
      #12;
      checks++;
      if ({o_prng_vld, o_vec_vld, o_busy, o_done, o_stop_hit} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {o_prng_vld, o_vec_vld, o_busy, o_done, o_stop_hit});
      end
      checks++;
      if (o_vec_cnt !== '0 || o_prng_stop_code !== '0 || o_prng_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_values: got cnt=%0d stop=%h data=%h expected all 0", o_vec_cnt, o_prng_stop_code, o_prng_data);
      end
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      i_vec_rdy = 1'b1;
      start_run(49'h1, 49'h1_2345_6789_ABCD, 10);
      wait_done(100);
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_done: got %b expected 1", o_done);
      end
      checks++;
      if (step_cnt != 10 || deliv_cnt != 10) begin
         errors++;
         $display("[TB] FAIL basic_counts: got steps=%0d delivered=%0d expected 10/10", step_cnt, deliv_cnt);
      end
      checks++;
      if (o_vec_cnt !== 16'd10) begin
         errors++;
         $display("[TB] FAIL basic_vec_cnt: got %0d expected 10", o_vec_cnt);
      end
      checks++;
      if (o_stop_hit !== 1'b0 || o_busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL basic_status: got stop_hit=%b busy=%b left=%0d expected 0/0/0", o_stop_hit, o_busy, exp_q.size());
      end
      checks++;
      if (o_prng_stop_code !== 49'h1_2345_6789_ABCD) begin
         errors++;
         $display("[TB] FAIL basic_stop_code: got %h expected %h", o_prng_stop_code, 49'h1_2345_6789_ABCD);
      end
   endtask

   task automatic test_backpressure();
      i_vec_rdy = 1'b0;
      start_run(49'h0_ABCD_E123, '1, 20);
      repeat (10) tick();
      #1;
      checks++;
      if (step_cnt != DEPTH || o_prng_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_credit: got steps=%0d prng_vld=%b expected %0d/0", step_cnt, o_prng_vld, DEPTH);
      end
      checks++;
      if (o_vec_vld !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_hold: got vec_vld=%b busy=%b expected 1/1", o_vec_vld, o_busy);
      end
      i_vec_rdy = 1'b1;
      wait_done(300);
      checks++;
      if (o_done !== 1'b1 || step_cnt != 20 || deliv_cnt != 20 || o_vec_cnt !== 16'd20) begin
         errors++;
         $display("[TB] FAIL bp_drain: got done=%b steps=%0d delivered=%0d cnt=%0d expected 1/20/20/20", o_done, step_cnt, deliv_cnt, o_vec_cnt);
      end
   endtask

   task automatic test_stop_code();
      i_vec_rdy = 1'b1;
      done_at = 5;
      start_run(49'h1_0000_0000_0007, 49'h5, 100);
      wait_done(300);
      done_at = 0;
      checks++;
      if (step_cnt != 5 || deliv_cnt != 5 || o_vec_cnt !== 16'd5) begin
         errors++;
         $display("[TB] FAIL stop_counts: got steps=%0d delivered=%0d cnt=%0d expected 5/5/5", step_cnt, deliv_cnt, o_vec_cnt);
      end
      checks++;
      if (o_stop_hit !== 1'b1 || o_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stop_status: got stop_hit=%b done=%b expected 1/1", o_stop_hit, o_done);
      end
   endtask

   task automatic test_abort();
      int steps_at_abort;
      i_vec_rdy = 1'b0;
      start_run(49'h0_5555_AAAA, '0, 50);
      #1;
      checks++;
      if (o_stop_hit !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_stop_cleared: got %b expected 0", o_stop_hit);
      end
      tick();
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      steps_at_abort = step_cnt;
      i_vec_rdy = 1'b1;
      wait_done(200);
      checks++;
      if (step_cnt != steps_at_abort || step_cnt == 0 || step_cnt >= 50) begin
         errors++;
         $display("[TB] FAIL abort_steps: got %0d after abort (%0d at abort) expected unchanged and 1..49", step_cnt, steps_at_abort);
      end
      checks++;
      if (o_done !== 1'b1 || deliv_cnt != step_cnt || o_vec_cnt !== CW'(step_cnt) || o_stop_hit !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_drain: got done=%b delivered=%0d cnt=%0d stop_hit=%b expected 1/%0d/%0d/0", o_done, deliv_cnt, o_vec_cnt, o_stop_hit, step_cnt, step_cnt);
      end
   endtask

   task automatic test_zero_max();
      i_vec_rdy = 1'b1;
      start_run(49'h3, '0, 0);
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_first_cycle: got busy=%b done=%b expected 1/0", o_busy, o_done);
      end
      tick();
      checks++;
      if (o_done !== 1'b1 || step_cnt != 0 || o_vec_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL zero_done: got done=%b steps=%0d cnt=%0d expected 1/0/0", o_done, step_cnt, o_vec_cnt);
      end
   endtask

   task automatic test_start_ignored();
      i_vec_rdy = 1'b1;
      start_run(49'h0_0000_BEEF, '0, 8);
      tick();
      i_start   = 1'b1;
      i_max_vec = 16'd2;
      i_seed    = 49'h7;
      tick();
      i_start   = 1'b0;
      wait_done(100);
      checks++;
      if (o_done !== 1'b1 || step_cnt != 8 || deliv_cnt != 8 || o_vec_cnt !== 16'd8) begin
         errors++;
         $display("[TB] FAIL start_ignored: got done=%b steps=%0d delivered=%0d cnt=%0d expected 1/8/8/8", o_done, step_cnt, deliv_cnt, o_vec_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      i_vec_rdy = 1'b0;
      start_run(49'h0_1357_9BDF, '0, 20);
      for (int c = 0; c < 20; c++) begin
         tick();
         #1;
         if (resp_cnt >= 3) break;
      end
      tick();
      #1;
      checks++;
      if (o_vec_vld !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_precond: got vec_vld=%b busy=%b expected 1/1", o_vec_vld, o_busy);
      end
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_vec_vld !== 1'b0 || o_busy !== 1'b0 || o_prng_vld !== 1'b0 || o_vec_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL rst_immediate: got vec_vld=%b busy=%b prng_vld=%b cnt=%0d expected 0/0/0/0", o_vec_vld, o_busy, o_prng_vld, o_vec_cnt);
      end
      tick();
      tick();
      exp_q.delete();
      i_rst = 1'b0;
      tick();
      test_basic();
   endtask

   initial begin
      i_abort = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_stop_code();
      test_abort();
      test_zero_max();
      test_start_ignored();
      test_reset_mid_run();
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
